ibus_fetch_initiator: RTL and testbench
=======================================

// Module: ibus_fetch_initiator
// PURPOSE
// Initiator end of the instruction bus (io_bus_req_* / io_bus_resp_*). Sits in the Core front end.
// - Generates sequential fetch addresses and tracks in-flight requests.
// - Pairs each returned instruction word with its PC and buffers both for decode.
// - On redirect, flushes the buffer and discards stale responses.
// PARAMETERS
// RESET_PC         32'h8000_0000  first fetch address after reset
// MAX_OUTSTANDING  2              max requests in flight (1..7)
// FIFO_DEPTH       4              decode-side buffer entries (>= MAX_OUTSTANDING, power of 2)
// PORTS
// clock              in   1   single clock, all logic on rising edge
// reset              in   1   synchronous, active-high
// io_bus_req_valid   out  1   request issued this cycle (no req ready: every valid cycle is one request)
// io_bus_req_bits    out  32  fetch address, 4-byte aligned
// io_bus_resp_valid  in   1   instruction word returning, in request order
// io_bus_resp_ready  out  1   initiator accepts response
// io_bus_resp_bits   in   32  instruction word
// io_redirect_valid  in   1   branch/exception redirect
// io_redirect_pc     in   32  new fetch address (bits[1:0] ignored, treated 0)
// io_inst_valid      out  1   buffered instruction available
// io_inst_ready      in   1   decode accepts
// io_inst_pc         out  32  PC of head instruction
// io_inst_bits       out  32  head instruction word
// BEHAVIOUR
// - Reset: req_valid=0, resp_ready=0, inst_valid=0, fetch_pc=RESET_PC, outstanding=0, drop_cnt=0, FIFO empty.
//   Reset mid-operation abandons everything; responses arriving in the reset cycle are ignored.
// - FSM
//   - IDLE: entered from reset; exactly 1 cycle; -> FETCH.
//   - FETCH: normal operation.
// - Issue, in FETCH only: req_valid = !redirect_valid && outstanding < MAX_OUTSTANDING
//   && (outstanding - drop_cnt + fifo_count) < FIFO_DEPTH.
//   - req_bits = fetch_pc.
//   - On issue: fetch_pc += 4 (wraps at 2^32); push fetch_pc into the pc queue (depth MAX_OUTSTANDING).
// - resp_ready = 1 in FETCH. Credits guarantee FIFO space, so no backpressure ever reaches the bus.
// - Response accept (resp_valid && resp_ready):
//   - outstanding decrements.
//   - If drop_cnt>0: word discarded, drop_cnt decrements.
//   - Else: pop the pc queue, push {pc, bits} into the FIFO.
//   - Latency: accepted cycle N -> io_inst_valid cycle N+1 (registered FIFO, no bypass).
// - outstanding: +1 on issue, -1 on accept; both in one cycle leaves it unchanged.
// - Redirect cycle:
//   - No issue; inst_valid forced 0, so no decode handshake.
//   - FIFO and pc queue flushed.
//   - drop_cnt <= outstanding minus any response accepted that cycle; a same-cycle response is discarded.
//   - fetch_pc <= {redirect_pc[31:2],2'b00}; first new request is issued the next cycle.
// - Back-to-back redirects: the last one wins, and drop_cnt is recomputed each time.
// - Decode handshake (inst_valid && inst_ready) pops the FIFO head. A simultaneous push and pop keeps the count.
// - FIFO full: issue is already blocked by the credit check, so an overflow is impossible.
// - Empty: inst_valid=0; pc/bits hold their last values and are don't-care.
// - resp_valid with outstanding==0 is a protocol error: ignored, flagged by a simulation-only assertion.
// - Counters are sized $clog2(MAX_OUTSTANDING+1) and $clog2(FIFO_DEPTH+1), with no wrap in legal operation.
// TESTING
// - Reset then zero-latency responder, inst_ready=1 -> req_bits 0x80000000,0x80000004,...; each inst appears 1 cycle after resp, pc matches.
// - inst_ready=0, responder always returns -> exactly 4 requests issued, FIFO holds 4, req_valid stays 0 until a pop.
// - Responder latency 3 cycles -> never more than 2 outstanding; req_valid toggles; order preserved.
// - 2 outstanding, redirect to 0x80001002 -> both stale responses dropped; next req_bits=0x80001000; first inst pc=0x80001000.
// - Redirect in the same cycle as a response and an inst handshake -> response dropped, FIFO empty next cycle, no duplicate pc.
// - fetch_pc 0xFFFFFFFC -> next req 0x00000000; reset asserted mid-stream -> all outputs 0 the next cycle, restart at RESET_PC.

Source files
------------

// File: rtl/ibus_fetch_initiator.sv
// Instruction-bus fetch initiator: issues sequential fetches under a credit limit,
// pairs returned words with their PCs in a decode FIFO, and drops stale responses after a redirect.
module ibus_fetch_initiator #(
  parameter logic [31:0] RESET_PC        = 32'h8000_0000,
  parameter int          MAX_OUTSTANDING = 2,
  parameter int          FIFO_DEPTH      = 4
) (
  input  logic        clock,
  input  logic        reset,
  output logic        io_bus_req_valid,
  output logic [31:0] io_bus_req_bits,
  input  logic        io_bus_resp_valid,
  output logic        io_bus_resp_ready,
  input  logic [31:0] io_bus_resp_bits,
  input  logic        io_redirect_valid,
  input  logic [31:0] io_redirect_pc,
  output logic        io_inst_valid,
  input  logic        io_inst_ready,
  output logic [31:0] io_inst_pc,
  output logic [31:0] io_inst_bits
);
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam int FW = $clog2(FIFO_DEPTH + 1);
  localparam int CW = FW + 1;
  localparam int QW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [OW-1:0] MAX_O   = OW'(MAX_OUTSTANDING);
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [QW-1:0] PQ_LAST = QW'(MAX_OUTSTANDING - 1);
  localparam logic [AW-1:0] FQ_LAST = AW'(FIFO_DEPTH - 1);

  typedef enum logic {S_IDLE, S_FETCH} state_t;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] bits;
  } inst_t;

  state_t          state_q, state_d;
  logic [31:0]     fetch_pc;
  logic [OW-1:0]   outstanding, drop_cnt;
  logic [FW-1:0]   fifo_count;
  logic [QW-1:0]   pq_wr, pq_rd;
  logic [AW-1:0]   fq_wr, fq_rd;
  logic [31:0]     pq_mem [MAX_OUTSTANDING];
  inst_t           fq_mem [FIFO_DEPTH];
  logic [CW-1:0]   in_use;
  logic            issue, accept, keep, pop;

  function automatic logic [QW-1:0] pq_inc(input logic [QW-1:0] p);
    return (p == PQ_LAST) ? '0 : p + 1'b1;
  endfunction

  function automatic logic [AW-1:0] fq_inc(input logic [AW-1:0] p);
    return (p == FQ_LAST) ? '0 : p + 1'b1;
  endfunction

  // Entries already committed to the FIFO: live in-flight requests plus buffered words.
  assign in_use = CW'(outstanding) - CW'(drop_cnt) + CW'(fifo_count);

  always_ff @(posedge clock) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d           = state_q;
    io_bus_req_valid  = 1'b0;
    io_bus_resp_ready = 1'b0;
    case (state_q)
      S_IDLE:  state_d = S_FETCH;
      S_FETCH: begin
        io_bus_resp_ready = 1'b1;
        io_bus_req_valid  = !io_redirect_valid && (outstanding < MAX_O) && (in_use < DEPTH_C);
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign io_bus_req_bits = fetch_pc;
  assign issue  = io_bus_req_valid;
  // A response with nothing outstanding is a protocol error and is ignored.
  assign accept = io_bus_resp_valid && io_bus_resp_ready && (outstanding != '0);
  assign keep   = accept && !io_redirect_valid && (drop_cnt == '0);
  assign io_inst_valid = (fifo_count != '0) && !io_redirect_valid;
  assign pop    = io_inst_valid && io_inst_ready;
  assign io_inst_pc   = fq_mem[fq_rd].pc;
  assign io_inst_bits = fq_mem[fq_rd].bits;

  always_ff @(posedge clock) begin
    if (reset) begin
      fetch_pc    <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
      fifo_count  <= '0;
      pq_wr       <= '0;
      pq_rd       <= '0;
      fq_wr       <= '0;
      fq_rd       <= '0;
    end else begin
      if (issue && !accept)      outstanding <= outstanding + 1'b1;
      else if (!issue && accept) outstanding <= outstanding - 1'b1;

      if (io_redirect_valid) begin
        // Everything still in flight after this cycle belongs to the old stream.
        drop_cnt   <= outstanding - OW'(accept);
        fetch_pc   <= io_redirect_pc & 32'hFFFF_FFFC;
        fifo_count <= '0;
        pq_wr      <= '0;
        pq_rd      <= '0;
        fq_wr      <= '0;
        fq_rd      <= '0;
      end else begin
        if (accept && (drop_cnt != '0)) drop_cnt <= drop_cnt - 1'b1;
        if (issue) begin
          fetch_pc <= fetch_pc + 32'd4;
          pq_wr    <= pq_inc(pq_wr);
        end
        if (keep) begin
          pq_rd <= pq_inc(pq_rd);
          fq_wr <= fq_inc(fq_wr);
        end
        if (pop) fq_rd <= fq_inc(fq_rd);
        if (keep && !pop)      fifo_count <= fifo_count + 1'b1;
        else if (!keep && pop) fifo_count <= fifo_count - 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (issue) pq_mem[pq_wr] <= fetch_pc;
    if (keep)  fq_mem[fq_wr] <= '{pc: pq_mem[pq_rd], bits: io_bus_resp_bits};
  end

  a_resp_with_outstanding: assert property (@(posedge clock) disable iff (reset)
    (io_bus_resp_valid && io_bus_resp_ready) |-> (outstanding != '0));

endmodule

// File: tb/tb_ibus_fetch_initiator.sv
// Randomized bench for ibus_fetch_initiator against a transaction-level model:
// queues of in-flight fetches and buffered instructions, updated from the fetch rules each cycle.
module tb_ibus_fetch_initiator;
  localparam logic [31:0] RESET_PC = 32'h8000_0000;
  localparam int MAX_OUT = 2;
  localparam int DEPTH   = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid, resp_ready, inst_valid;
  logic [31:0] req_bits, inst_pc, inst_bits;
  logic        resp_valid = 1'b0, redirect_valid = 1'b0, inst_ready = 1'b0;
  logic [31:0] resp_bits = '0, redirect_pc = '0;

  ibus_fetch_initiator #(.RESET_PC(RESET_PC), .MAX_OUTSTANDING(MAX_OUT), .FIFO_DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset),
    .io_bus_req_valid(req_valid), .io_bus_req_bits(req_bits),
    .io_bus_resp_valid(resp_valid), .io_bus_resp_ready(resp_ready), .io_bus_resp_bits(resp_bits),
    .io_redirect_valid(redirect_valid), .io_redirect_pc(redirect_pc),
    .io_inst_valid(inst_valid), .io_inst_ready(inst_ready),
    .io_inst_pc(inst_pc), .io_inst_bits(inst_bits)
  );

  always #5 clock = ~clock;

  typedef struct { logic [31:0] pc; bit stale; int t; } fl_t;
  typedef struct { logic [31:0] pc; logic [31:0] w; } ent_t;

  fl_t         inflight[$];
  ent_t        fifo[$];
  logic [31:0] m_pc = RESET_PC;
  bit          idle = 1'b1;
  int          cyc = 0;
  int          n_chk = 0, n_pass = 0;
  int          lat = 0, resp_pct = 100, rdy_pct = 100, redir_pm = 0;
  bit          f_redir = 0, f_resp = 0, f_rdy = 0;
  logic [31:0] f_pc = '0;

  function automatic logic [31:0] word_of(input logic [31:0] pc);
    return {pc[15:0], ~pc[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s cyc=%0d: got %h expected %h", tag, cyc, obs, exp);
  endtask

  task automatic step();
    bit   rdir, ok, exp_req, exp_iv, acc;
    int   live;
    fl_t  e;
    @(negedge clock);
    reset = 1'b0;
    rdir = f_redir || ($urandom_range(999) < redir_pm);
    redirect_valid = rdir;
    redirect_pc = f_redir ? f_pc : ($urandom & 32'h8000_FFFF);
    ok = (inflight.size() > 0) && ((cyc - inflight[0].t) > lat);
    resp_valid = ok && (f_resp || ($urandom_range(99) < resp_pct));
    resp_bits  = resp_valid ? word_of(inflight[0].pc) : $urandom;
    inst_ready = f_rdy || ($urandom_range(99) < rdy_pct);
    f_redir = 0; f_resp = 0; f_rdy = 0;
    #1;
    live = 0;
    foreach (inflight[i]) if (!inflight[i].stale) live++;
    exp_req = !idle && !rdir && (inflight.size() < MAX_OUT) && ((live + fifo.size()) < DEPTH);
    chk("req_valid", 32'(req_valid), 32'(exp_req));
    if (exp_req) chk("req_bits", req_bits, m_pc);
    chk("resp_ready", 32'(resp_ready), 32'(!idle));
    exp_iv = (fifo.size() > 0) && !rdir;
    chk("inst_valid", 32'(inst_valid), 32'(exp_iv));
    if (exp_iv) begin
      chk("inst_pc", inst_pc, fifo[0].pc);
      chk("inst_bits", inst_bits, fifo[0].w);
    end
    acc = resp_valid && !idle;
    if (rdir) begin
      if (acc) void'(inflight.pop_front());
      foreach (inflight[i]) inflight[i].stale = 1'b1;
      fifo.delete();
      m_pc = {redirect_pc[31:2], 2'b00};
    end else begin
      if (exp_iv && inst_ready) void'(fifo.pop_front());
      if (acc) begin
        e = inflight.pop_front();
        if (!e.stale) fifo.push_back('{pc: e.pc, w: resp_bits});
      end
      if (exp_req) begin
        inflight.push_back('{pc: m_pc, stale: 1'b0, t: cyc});
        m_pc = m_pc + 32'd4;
      end
    end
    idle = 1'b0;
    cyc++;
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      reset = 1'b1;
      resp_valid = 1'($urandom_range(1));
      resp_bits = $urandom;
      redirect_valid = 1'b0;
      inst_ready = 1'b1;
      cyc++;
    end
    inflight.delete();
    fifo.delete();
    m_pc = RESET_PC;
    idle = 1'b1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    // Zero-latency responder, decode always ready.
    do_reset(2);
    lat = 0; resp_pct = 100; rdy_pct = 100; redir_pm = 0;
    run(40);

    // Decode stalled: FIFO fills to 4 and issue stops, then drains.
    rdy_pct = 0;
    run(20);
    rdy_pct = 100;
    run(12);

    // Three-cycle latency keeps the outstanding limit busy.
    lat = 3;
    run(30);

    // Redirect with two fetches in flight; both stale words must be dropped.
    begin
      int i;
      for (i = 0; i < 50 && inflight.size() != MAX_OUT; i++) step();
      n_chk++;
      assert (inflight.size() == MAX_OUT) n_pass++;
      else $error("FAIL wait_two_outstanding: got %0d expected %0d", inflight.size(), MAX_OUT);
    end
    f_redir = 1; f_pc = 32'h8000_1002;
    step();
    run(20);

    // Redirect coinciding with a response and a decode-ready cycle.
    lat = 0; rdy_pct = 0;
    begin
      int i;
      for (i = 0; i < 50 && !(fifo.size() > 0 && inflight.size() > 0 && (cyc - inflight[0].t) > lat); i++)
        step();
      n_chk++;
      assert (fifo.size() > 0 && inflight.size() > 0) n_pass++;
      else $error("FAIL wait_mixed_redirect: got fifo=%0d inflight=%0d expected both nonzero",
                  fifo.size(), inflight.size());
    end
    f_redir = 1; f_resp = 1; f_rdy = 1; f_pc = 32'h8000_2000;
    step();
    rdy_pct = 100;
    run(10);

    // PC wrap across 2^32.
    f_redir = 1; f_pc = 32'hFFFF_FFF8;
    step();
    run(12);

    // Randomized mix of latency, stalls and redirects.
    for (int ph = 0; ph < 6; ph++) begin
      lat = $urandom_range(3); resp_pct = 40 + $urandom_range(60);
      rdy_pct = 30 + $urandom_range(70); redir_pm = 40;
      run(60);
    end

    // Reset mid-stream, then restart from RESET_PC.
    redir_pm = 0; lat = 1; resp_pct = 100; rdy_pct = 80;
    do_reset(1);
    run(30);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
